// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a level req/ack handshake with imem, feeds IF/ID.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// FETCH | request to imem at pc held until ack
// HOLD  | fetched instr parked while downstream stalls, no request
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic                   o_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_write_en,
  output logic [31:0]            o_fetch_cnt,
  output logic [31:0]            o_stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  pc, pc_n;
  logic                   drop, drop_n;
  logic                   flush_pend, flush_pend_n;
  logic [INSTR_WIDTH-1:0] hold_instr, hold_instr_n;
  logic                   valid_n;
  logic [ADDR_WIDTH-1:0]  opc_n;
  logic [INSTR_WIDTH-1:0] oinstr_n;
  logic                   deliver;

  assign o_imem_req  = (state == FETCH);
  assign o_imem_addr = pc;
  assign o_write_en  = ~i_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      flush_pend <= 1'b0;
      hold_instr <= '0;
      o_valid    <= 1'b0;
      o_pc       <= '0;
      o_instr    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      flush_pend <= flush_pend_n;
      hold_instr <= hold_instr_n;
      o_valid    <= valid_n;
      o_pc       <= opc_n;
      o_instr    <= oinstr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drop_n       = drop;
    flush_pend_n = flush_pend;
    hold_instr_n = hold_instr;
    valid_n      = o_valid;
    opc_n        = o_pc;
    oinstr_n     = o_instr;
    deliver      = 1'b0;

    if (i_redirect) begin
      // Only a FETCH without ack this cycle leaves a response in flight to discard.
      pc_n         = i_redirect_pc;
      state_n      = FETCH;
      drop_n       = (state == FETCH) && !i_imem_ack;
      flush_pend_n = i_stall;
      if (!i_stall) valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (i_imem_ack) begin
            drop_n = 1'b0;
            if (!drop) begin
              if (i_stall || flush_pend) begin
                hold_instr_n = i_imem_data;
                state_n      = HOLD;
              end else begin
                deliver  = 1'b1;
                valid_n  = 1'b1;
                opc_n    = pc;
                oinstr_n = i_imem_data;
                pc_n     = pc + STEP;
              end
            end
          end
        end
        HOLD: begin
          if (!i_stall && !flush_pend) begin
            deliver  = 1'b1;
            valid_n  = 1'b1;
            opc_n    = pc;
            oinstr_n = hold_instr;
            pc_n     = pc + STEP;
            state_n  = FETCH;
          end
        end
        default: state_n = IDLE;
      endcase
      // A flush deferred by a stall becomes the bubble on the first free cycle.
      if (!i_stall && !deliver) valid_n = 1'b0;
      if (!i_stall) flush_pend_n = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(deliver);
      stall_cnt <= stall_cnt + 32'(i_stall);
    end
  end

  assign o_fetch_cnt = fetch_cnt;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_fetch_cnt = 32'h0;
  assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a behavioural
// fetch/delivery model and a variable-latency level-handshake memory model.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_stall = 1'b0, i_redirect = 1'b0, i_imem_ack = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_imem_data = '0;
  logic        o_imem_req, o_valid, o_write_en;
  logic [31:0] o_imem_addr, o_pc, o_instr, o_fetch_cnt, o_stall_cnt;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data), .o_valid(o_valid), .o_pc(o_pc),
    .o_instr(o_instr), .o_write_en(o_write_en), .o_fetch_cnt(o_fetch_cnt),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  // memory model state
  bit          mem_active, mem_stale, spur_en, spur_force;
  logic [31:0] mem_addr;
  int          mem_cnt, mem_lat, lat_min = 1, lat_max = 1;

  // behavioural model state
  logic [31:0] m_pc, m_opc, m_oinstr, m_hold_instr;
  bit          m_v, m_hold, m_pend, m_started;
  int unsigned m_fetches, m_stalls;
  logic        we_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  task automatic model_clear();
    mem_active = 0; mem_stale = 0; mem_cnt = 0; spur_force = 0;
    m_pc = 32'h0; m_opc = 32'h0; m_oinstr = 32'h0; m_hold_instr = 32'h0;
    m_v = 0; m_hold = 0; m_pend = 0; m_started = 0; m_fetches = 0; m_stalls = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_stall = 0; i_redirect = 0; i_redirect_pc = '0; i_imem_ack = 0; i_imem_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock of stimulus: memory responds to the DUT request, model advances, then the edge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
    logic        ack;
    logic [31:0] data;
    bit          accepted;
    ack = 0; data = '0; accepted = 0;
    if (o_imem_req && !mem_active) begin
      mem_active = 1; mem_stale = 0; mem_addr = o_imem_addr; mem_cnt = 0;
      mem_lat = $urandom_range(lat_max, lat_min);
    end
    if (mem_active) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin ack = 1; data = mem_word(mem_addr); end
    end else if (spur_force || (spur_en && $urandom_range(0, 3) == 0)) begin
      ack = 1; data = $urandom;
    end
    spur_force = 0;
    i_stall = st; i_redirect = rd; i_redirect_pc = rpc; i_imem_ack = ack; i_imem_data = data;
    #1 we_seen = o_write_en;
    if (mem_active) begin
      if (ack) begin accepted = !mem_stale && !rd; mem_active = 0; end
      else if (rd) mem_stale = 1;
    end
    if (rd) begin
      m_pc = rpc; m_hold = 0;
      if (!st) begin m_v = 0; m_pend = 0; end else m_pend = 1;
    end else if (st) begin
      if (accepted) begin m_hold = 1; m_hold_instr = data; end
    end else if (m_pend) begin
      m_v = 0; m_pend = 0;
      if (accepted) begin m_hold = 1; m_hold_instr = data; end
    end else if (m_hold || accepted) begin
      m_v = 1; m_opc = m_pc; m_oinstr = m_hold ? m_hold_instr : data;
      m_pc = m_pc + 32'd4; m_hold = 0; m_fetches++;
    end else begin
      m_v = 0;
    end
    if (st) m_stalls++;
    m_started = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_valid, o_pc, o_instr, o_imem_req} !== 66'h0) begin
      bad++; $display("FAIL reset_outputs: got v=%b pc=%h instr=%h req=%b want all 0", o_valid, o_pc, o_instr, o_imem_req);
    end
    total++;
    if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", o_imem_addr); end
    total++;
    if ({o_fetch_cnt, o_stall_cnt} !== 64'h0) begin
      bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", o_fetch_cnt, o_stall_cnt);
    end
    total++;
    if (o_write_en !== 1'b1) begin bad++; $display("FAIL reset_we: got %b want 1", o_write_en); end
  endtask

  task automatic test_stream();
    do_reset(); lat_min = 1; lat_max = 1; spur_en = 0;
    cycle(0, 0, 0);
    total++;
    if ({o_imem_req, o_valid} !== 2'b10) begin bad++; $display("FAIL stream_first_req: got req=%b v=%b want 1/0", o_imem_req, o_valid); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0);
      total++;
      if ({o_valid, o_pc, o_instr} !== {1'b1, 32'(4 * i), 32'(i + 1)}) begin
        bad++; $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want 1 %h %h", i, o_valid, o_pc, o_instr, 4 * i, i + 1);
      end
    end
  endtask

  task automatic test_latency();
    do_reset(); lat_min = 3; lat_max = 3; spur_en = 0;
    cycle(0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cycle(0, 0, 0);
      total++;
      if (o_valid !== (k % 3 == 0)) begin bad++; $display("FAIL lat_valid_%0d: got %b want %b", k, o_valid, k % 3 == 0); end
      total++;
      if ({o_imem_req, o_imem_addr} !== {1'b1, 32'(4 * (k / 3))}) begin
        bad++; $display("FAIL lat_addr_%0d: got req=%b addr=%h want 1 %h", k, o_imem_req, o_imem_addr, 4 * (k / 3));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(); lat_min = 1; lat_max = 1; spur_en = 0;
    cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0);
      total++;
      if (we_seen !== 1'b0) begin bad++; $display("FAIL stall_we_%0d: got %b want 0", k, we_seen); end
      total++;
      if ({o_valid, o_pc, o_imem_req} !== {1'b1, 32'h8, 1'b0}) begin
        bad++; $display("FAIL stall_hold_%0d: got v=%b pc=%h req=%b want 1 8 0", k, o_valid, o_pc, o_imem_req);
      end
    end
    cycle(0, 0, 0);
    total++;
    if ({o_valid, o_pc, o_instr} !== {1'b1, 32'hC, 32'h4}) begin
      bad++; $display("FAIL stall_resume: got v=%b pc=%h instr=%h want 1 c 4", o_valid, o_pc, o_instr);
    end
    cycle(0, 0, 0);
    total++;
    if ({o_valid, o_pc} !== {1'b1, 32'h10}) begin bad++; $display("FAIL stall_next: got v=%b pc=%h want 1 10", o_valid, o_pc); end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset(); lat_min = 1; lat_max = 1; spur_en = 0;
    cycle(0, 0, 0);
    repeat (4) cycle(0, 0, 0);
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0);
    total++;
    if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 32'h10, 1'b0}) begin
      bad++; $display("FAIL redir_pre: got req=%b addr=%h v=%b want 1 10 0", o_imem_req, o_imem_addr, o_valid);
    end
    cycle(0, 1, 32'h100);
    total++;
    if ({o_imem_addr, o_valid} !== {32'h100, 1'b0}) begin
      bad++; $display("FAIL redir_addr: got addr=%h v=%b want 100 0", o_imem_addr, o_valid);
    end
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      cycle(0, 0, 0);
      if (o_valid) begin
        seen = 1;
        total++;
        if ({o_pc, o_instr} !== {32'h100, 32'h41}) begin
          bad++; $display("FAIL redir_first: got pc=%h instr=%h want 100 41", o_pc, o_instr);
        end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL redir_timeout: got no valid want pc=100"); end
  endtask

  task automatic test_wrap();
    do_reset(); lat_min = 1; lat_max = 1; spur_en = 0;
    cycle(0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      cycle(0, 0, 0);
      total++;
      if ({o_valid, o_pc, o_instr} !== {1'b1, e, mem_word(e)}) begin
        bad++; $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h want 1 %h %h", i, o_valid, o_pc, o_instr, e, mem_word(e));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(); lat_min = 3; lat_max = 3; spur_en = 0;
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({o_valid, o_pc, o_instr, o_imem_req, o_fetch_cnt, o_stall_cnt} !== 130'h0) begin
      bad++; $display("FAIL arst_outputs: got v=%b pc=%h instr=%h req=%b want all 0", o_valid, o_pc, o_instr, o_imem_req);
    end
    total++;
    if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr: got %h want 0", o_imem_addr); end
    i_imem_ack = 0;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
    spur_force = 1;
    cycle(0, 0, 0);
    total++;
    if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL arst_stale_ack: got v=%b req=%b addr=%h want 0 1 0", o_valid, o_imem_req, o_imem_addr);
    end
    repeat (3) cycle(0, 0, 0);
    total++;
    if ({o_valid, o_pc, o_instr} !== {1'b1, 32'h0, 32'h1}) begin
      bad++; $display("FAIL arst_restart: got v=%b pc=%h instr=%h want 1 0 1", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_perf();
    do_reset(); lat_min = 1; lat_max = 1; spur_en = 0;
    cycle(0, 0, 0);
    repeat (5) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    total++;
    if (o_fetch_cnt !== (PERF ? 32'd10 : 32'd0)) begin
      bad++; $display("FAIL perf_fetch: got %0d want %0d", o_fetch_cnt, PERF ? 10 : 0);
    end
    total++;
    if (o_stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL perf_stall: got %0d want %0d", o_stall_cnt, PERF ? 3 : 0);
    end
  endtask

  task automatic test_random();
    bit          st, rd;
    logic [31:0] rpc;
    do_reset(); lat_min = 1; lat_max = 4; spur_en = 1;
    for (int n = 0; n < 1500; n++) begin
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF4;
      cycle(st, rd, rpc);
      total++;
      if (we_seen !== ~st) begin bad++; $display("FAIL rnd_we@%0d: got %b want %b", n, we_seen, ~st); end
      total++;
      if ({o_valid, o_pc, o_instr} !== {m_v, m_opc, m_oinstr}) begin
        bad++; $display("FAIL rnd_out@%0d: got v=%b pc=%h instr=%h want %b %h %h", n, o_valid, o_pc, o_instr, m_v, m_opc, m_oinstr);
      end
      total++;
      if ({o_imem_req, o_imem_addr} !== {m_started && !m_hold, m_pc}) begin
        bad++; $display("FAIL rnd_req@%0d: got req=%b addr=%h want %b %h", n, o_imem_req, o_imem_addr, m_started && !m_hold, m_pc);
      end
      total++;
      if ({o_fetch_cnt, o_stall_cnt} !== (PERF ? {m_fetches, m_stalls} : 64'h0)) begin
        bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n, o_fetch_cnt, o_stall_cnt,
                        PERF ? m_fetches : 0, PERF ? m_stalls : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
